// File: rtl/trackball_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : trackball_emu_if
// Purpose  : Joystick/mouse inputs and position-counter outputs of trackball_emu.
// Revision : 1.0
// ============================================================================
interface trackball_emu_if;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       flip;
   logic       mouse_strobe;
   logic [8:0] mouse_dx;
   logic [8:0] mouse_dy;
   logic [3:0] horz;
   logic [3:0] vert;
   logic       horz_dir;
   logic       vert_dir;

   modport master (
      output up, down, left, right, flip, mouse_strobe, mouse_dx, mouse_dy,
      input  horz, vert, horz_dir, vert_dir
   );

   modport slave (
      input  up, down, left, right, flip, mouse_strobe, mouse_dx, mouse_dy,
      output horz, vert, horz_dir, vert_dir
   );
endinterface
`default_nettype wire

// File: rtl/trackball_emu.sv
`default_nettype none
// ============================================================================
// Module   : trackball_emu
// Purpose  : Crystal Castles trackball emulation from joystick and mouse deltas.
//            Optional feature macro: TRACKBALL_ACCEL_EN (held-direction speed-up).
// Revision : 1.0
// ============================================================================
module trackball_emu #(
   parameter int TICK_DIV    = 50000,
   parameter int MAX_SPEED   = 4,
   parameter int ACCEL_STEPS = 16
) (
   input  wire logic      clk,
   input  wire logic      reset_n,
   trackball_emu_if.slave bus
);
   localparam int                   C_PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [C_PRESC_W-1:0] C_TICK_LAST = C_PRESC_W'(TICK_DIV - 1);

   logic [C_PRESC_W-1:0] presc_q;
   logic [C_PRESC_W-1:0] presc_d;
   logic                 tick;

   always_comb begin
      tick    = (presc_q == C_TICK_LAST);
      presc_d = tick ? '0 : presc_q + C_PRESC_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Axis 0 is horizontal (right positive), axis 1 vertical (down positive).
   logic [1:0] w_pos_in;
   logic [1:0] w_neg_in;
   logic [8:0] w_mouse_in [2];
   logic [3:0] w_count    [2];
   logic [1:0] w_dir;

   assign w_pos_in      = {bus.down, bus.right};
   assign w_neg_in      = {bus.up,   bus.left};
   assign w_mouse_in[0] = bus.mouse_dx;
   assign w_mouse_in[1] = bus.mouse_dy;

`ifdef TRACKBALL_ACCEL_EN
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } axis_state_t;

   localparam logic [2:0] C_MAX_SPEED = 3'(MAX_SPEED);
   localparam logic [7:0] C_HOLD_LAST = 8'(ACCEL_STEPS - 1);
`else
   // Speed is pinned to 1; the acceleration parameters are folded in only so
   // that both builds elaborate the same parameter set.
   localparam logic [2:0] C_FIXED_SPEED = 3'(1 + 0 * (MAX_SPEED + ACCEL_STEPS));
`endif

   for (genvar a = 0; a < 2; a++) begin : g_axis
      logic signed [1:0] req;
      logic        [2:0] mag;
      logic signed [3:0] joy_step;
      logic signed [3:0] mouse_step;
      logic signed [4:0] step;
      logic        [3:0] count_q;
      logic        [3:0] count_d;
      logic              dir_q;
      logic              dir_d;
`ifdef TRACKBALL_ACCEL_EN
      axis_state_t       state_q;
      axis_state_t       state_d;
      logic signed [1:0] last_q;
      logic signed [1:0] last_d;
      logic        [2:0] speed_q;
      logic        [2:0] speed_d;
      logic        [7:0] hold_q;
      logic        [7:0] hold_d;
      logic        [7:0] cur_hold;
`endif

      always_comb begin
         req = 2'sd0;
         if (w_pos_in[a] && !w_neg_in[a]) begin
            req = 2'sd1;
         end else if (w_neg_in[a] && !w_pos_in[a]) begin
            req = -2'sd1;
         end
         if (bus.flip) begin
            req = -req;
         end
      end

      always_comb begin
         mouse_step = 4'sd0;
         if (bus.mouse_strobe) begin
            if ($signed(w_mouse_in[a]) > 9'sd7) begin
               mouse_step = 4'sd7;
            end else if ($signed(w_mouse_in[a]) < -9'sd7) begin
               mouse_step = -4'sd7;
            end else begin
               mouse_step = $signed(w_mouse_in[a][3:0]);
            end
            if (bus.flip) begin
               mouse_step = -mouse_step;
            end
         end
      end

      always_comb begin
         joy_step = 4'sd0;
`ifdef TRACKBALL_ACCEL_EN
         mag      = 3'd1;
         cur_hold = 8'd0;
         state_d  = state_q;
         last_d   = last_q;
         speed_d  = speed_q;
         hold_d   = hold_q;
         if (tick) begin
            last_d = req;
            if (req == 2'sd0) begin
               state_d = S_IDLE;
               speed_d = 3'd1;
               hold_d  = 8'd0;
            end else begin
               state_d = S_RUN;
               // A new direction restarts at speed 1 and counts as its first held tick.
               if (state_q == S_RUN && req == last_q) begin
                  mag      = speed_q;
                  cur_hold = hold_q;
               end
               if (cur_hold == C_HOLD_LAST) begin
                  hold_d  = 8'd0;
                  speed_d = (mag < C_MAX_SPEED) ? mag + 3'd1 : mag;
               end else begin
                  hold_d  = cur_hold + 8'd1;
                  speed_d = mag;
               end
               joy_step = req[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
            end
         end
`else
         mag = C_FIXED_SPEED;
         if (tick && req != 2'sd0) begin
            joy_step = req[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
         end
`endif
      end

      always_comb begin
         step    = {joy_step[3], joy_step} + {mouse_step[3], mouse_step};
         count_d = count_q + step[3:0];
         dir_d   = (step != 5'sd0) ? !step[4] : dir_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            count_q <= 4'd0;
            dir_q   <= 1'b0;
`ifdef TRACKBALL_ACCEL_EN
            state_q <= S_IDLE;
            last_q  <= 2'sd0;
            speed_q <= 3'd1;
            hold_q  <= 8'd0;
`endif
         end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
`ifdef TRACKBALL_ACCEL_EN
            state_q <= state_d;
            last_q  <= last_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
`endif
         end
      end

      assign w_count[a] = count_q;
      assign w_dir[a]   = dir_q;
   end

   assign bus.horz     = w_count[0];
   assign bus.vert     = w_count[1];
   assign bus.horz_dir = w_dir[0];
   assign bus.vert_dir = w_dir[1];

endmodule
`default_nettype wire
